// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: playfield geometry, motion constants and FSM states for the breakout ball.
package ball_motion_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int BALL_SIZE = 8;
  localparam int PADDLE_Y = 456;
  localparam int PADDLE_W = 64;
  localparam int SPEED = 2;
  localparam int LOST_TICKS = 60;
  localparam logic [9:0] SERVE_X = 10'd316;
  localparam logic [9:0] SERVE_Y = 10'd240;
  localparam logic [9:0] X_MAX = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] PADDLE_TOP = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic signed [10:0] D_POS = 11'(SPEED);
  localparam logic signed [10:0] D_NEG = 11'(-SPEED);
  localparam logic [7:0] LOST_LAST = 8'(LOST_TICKS - 1);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_LOST = 2'd2} state_t;
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one-axis step with clamp-and-reflect at the lo/hi walls.
module ball_axis import ball_motion_pkg::*; (
  input  logic [9:0]        pos,
  input  logic signed [10:0] d,
  input  logic [9:0]        lo,
  input  logic [9:0]        hi,
  output logic [9:0]        npos,
  output logic signed [10:0] nd,
  output logic              lo_hit,
  output logic              hi_hit
);
  logic signed [10:0] sum;
  assign sum = $signed({1'b0, pos}) + d;
  assign lo_hit = sum <= $signed({1'b0, lo});
  assign hi_hit = sum >= $signed({1'b0, hi});
  assign npos = lo_hit ? lo : hi_hit ? hi : sum[9:0];
  assign nd = lo_hit ? D_POS : hi_hit ? D_NEG : d;
endmodule

// File: rtl/ball_motion.sv
// ball_motion: breakout ball kinematics with serve/move/lost sequencing.
module ball_motion import ball_motion_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] paddle_x,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_on,
  output logic       miss,
  output logic       bounce
);
  state_t state;
  logic signed [10:0] dx, dy, ndx, ndy;
  logic [7:0] lost_cnt;
  logic [9:0] nx, ny;
  logic x_lo, x_hi, y_lo, y_hi, paddle_hit;
  ball_axis u_x (.pos(ball_x), .d(dx), .lo(10'd0), .hi(X_MAX), .npos(nx), .nd(ndx), .lo_hit(x_lo), .hi_hit(x_hi));
  // The Y "hi wall" is the bottom edge: its hit flags a miss rather than a reflection.
  ball_axis u_y (.pos(ball_y), .d(dy), .lo(10'd0), .hi(Y_MAX), .npos(ny), .nd(ndy), .lo_hit(y_lo), .hi_hit(y_hi));
  assign paddle_hit = !dy[10] && ball_y <= PADDLE_TOP && ny > PADDLE_TOP &&
                      ({1'b0, nx} + 11'(BALL_SIZE) > {1'b0, paddle_x}) &&
                      ({1'b0, nx} < {1'b0, paddle_x} + 11'(PADDLE_W));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ball_x <= SERVE_X;
      ball_y <= SERVE_Y;
      dx <= D_POS;
      dy <= D_NEG;
      ball_on <= 1'b1;
      miss <= 1'b0;
      bounce <= 1'b0;
      lost_cnt <= 8'd0;
    end else begin
      miss <= 1'b0;
      bounce <= 1'b0;
      case (state)
        ST_IDLE: if (serve) state <= ST_MOVE;
        ST_MOVE: if (tick) begin
          if (y_hi && !paddle_hit) begin
            miss <= 1'b1;
            ball_on <= 1'b0;
            lost_cnt <= 8'd0;
            state <= ST_LOST;
          end else begin
            ball_x <= nx;
            dx <= ndx;
            ball_y <= paddle_hit ? PADDLE_TOP : ny;
            dy <= paddle_hit ? D_NEG : ndy;
            bounce <= x_lo | x_hi | y_lo | paddle_hit;
          end
        end
        ST_LOST: if (tick) begin
          lost_cnt <= lost_cnt + 8'd1;
          if (lost_cnt == LOST_LAST) begin
            state <= ST_IDLE;
            ball_on <= 1'b1;
            ball_x <= SERVE_X;
            ball_y <= SERVE_Y;
            dx <= D_POS;
            dy <= D_NEG;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: randomized stimulus against a behavioural ball/serve model.
module tb_ball_motion;
  localparam int XMAX = 632, YBOT = 472, PTOP = 456, PW = 64, BS = 8, SP = 2;
  localparam int M_IDLE = 0, M_MOVE = 1, M_LOST = 2;
  logic clk = 0, reset, tick, serve, ball_on, miss, bounce;
  logic [9:0] paddle_x, ball_x, ball_y;
  int tests = 0, fails = 0;
  int mx, my, mdx, mdy, mst, mcnt, mode;
  bit mmiss, mbnc;

  ball_motion dut (.clk(clk), .reset(reset), .tick(tick), .paddle_x(paddle_x), .serve(serve),
                   .ball_x(ball_x), .ball_y(ball_y), .ball_on(ball_on), .miss(miss), .bounce(bounce));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_serve_pos();
    mx = 316; my = 240; mdx = SP; mdy = -SP;
  endtask

  task automatic model_reset();
    model_serve_pos();
    mst = M_IDLE; mcnt = 0; mmiss = 0; mbnc = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input int p);
    int nx, ny, ndx, ndy;
    bit b;
    mmiss = 0; mbnc = 0;
    if (mst == M_IDLE) begin
      if (s) mst = M_MOVE;
    end else if (mst == M_MOVE) begin
      if (t) begin
        nx = mx + mdx; ny = my + mdy; ndx = mdx; ndy = mdy; b = 0;
        if (nx <= 0) begin nx = 0; ndx = SP; b = 1; end
        else if (nx >= XMAX) begin nx = XMAX; ndx = -SP; b = 1; end
        if (ny <= 0) begin ny = 0; ndy = SP; b = 1; end
        else if (mdy > 0 && my + BS <= PTOP && ny + BS > PTOP && nx + BS > p && nx < p + PW) begin
          ny = PTOP - BS; ndy = -SP; b = 1;
        end else if (ny >= YBOT) begin
          mmiss = 1; mst = M_LOST; mcnt = 0;
        end
        if (!mmiss) begin mx = nx; my = ny; mdx = ndx; mdy = ndy; mbnc = b; end
      end
    end else if (t) begin
      mcnt++;
      if (mcnt == 60) begin mst = M_IDLE; model_serve_pos(); end
    end
  endtask

  task automatic compare_all();
    check("ball_x", ball_x, mx);
    check("ball_y", ball_y, my);
    check("ball_on", ball_on, mst != M_LOST);
    check("miss", miss, mmiss);
    check("bounce", bounce, mbnc);
  endtask

  task automatic run_cycle(input bit t, input bit s, input int p);
    tick = t; serve = s; paddle_x = 10'(p);
    @(posedge clk);
    model_step(t, s, p);
    #1 compare_all();
  endtask

  function automatic int pick_paddle(input int m);
    int v;
    case (m)
      0: v = mx - 20;
      1: v = $urandom_range(0, 1023);
      2: v = 0;
      3: v = mx + $urandom_range(0, 80) - 70;
      default: v = 1000;
    endcase
    return v < 0 ? 0 : v > 1023 ? 1023 : v;
  endfunction

  initial begin
    int gap, pd, waited;
    bit last_t;
    reset = 1; tick = 0; serve = 0; paddle_x = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", ball_x, 316);
    check("rst_y", ball_y, 240);
    check("rst_on", ball_on, 1);
    check("rst_miss", miss, 0);
    check("rst_bounce", bounce, 0);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1, 0, 300);
      run_cycle(0, 0, 300);
    end
    check("idle_hold_x", ball_x, 316);
    check("idle_hold_y", ball_y, 240);
    run_cycle(1, 1, 300);
    check("serve_tick_nostep", ball_x, 316);
    run_cycle(0, 0, 300);
    run_cycle(1, 0, 300);
    check("first_step_x", ball_x, 318);
    check("first_step_y", ball_y, 238);
    gap = 2; last_t = 0; mode = 0; pd = 300;
    for (int c = 0; c < 20000; c++) begin
      bit t, s;
      t = (gap == 0);
      gap = t ? $urandom_range(1, 4) : gap - 1;
      s = (mst == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      if (last_t) begin
        if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 3);
        pd = pick_paddle(mode);
      end
      run_cycle(t, s, pd);
      last_t = t;
    end
    waited = 0;
    while (mst != M_LOST && waited < 20000) begin
      run_cycle(waited % 3 == 0, mst == M_IDLE, 1000);
      waited++;
    end
    check("reach_lost", mst == M_LOST, 1);
    run_cycle(1, 0, 1000);
    #2 reset = 1;
    #2;
    check("async_rst_on", ball_on, 1);
    check("async_rst_x", ball_x, 316);
    check("async_rst_y", ball_y, 240);
    check("async_rst_miss", miss, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    run_cycle(1, 0, 300);
    run_cycle(0, 1, 300);
    run_cycle(1, 0, 300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
